// File: rtl/mina_fetch_unit.sv
// mina_fetch_unit: instruction fetch stage for the MINA CPU.
// Owns the fetch address and issues pipelined requests on a split
// request/response IMEM bus. Returned words go into a small prefetch queue
// that feeds the IF/ID boundary through a valid/ready handshake. A branch
// redirect flushes the queue and marks in-flight fetches to be dropped.
//
// Optional build macro: MINA_FETCH_PERF_EN adds three free-running
// performance counters (perf_fetched, perf_flushed, perf_stall).

module mina_fetch_unit #(
   parameter logic [31:0] INITIAL_IA  = 32'h0000_0000,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned MAX_DROP_W  = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   // IMEM request/response bus
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   // branch redirect
   input  logic        redirect_valid,
   input  logic [31:0] redirect_ia,
   // IF/ID handshake
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_ia,
   output logic [31:0] if_ia_plus_4,
   output logic [31:0] if_ir
`ifdef MINA_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed,
   output logic [31:0] perf_stall
`endif
);

   localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

   typedef logic [MAX_DROP_W-1:0] cnt_t;
   typedef logic [MAX_DROP_W:0]   sum_t;
   typedef logic [PTR_W-1:0]      ptr_t;

   localparam sum_t DEPTH_SUM = sum_t'(QUEUE_DEPTH);
   localparam cnt_t CNT_ONE   = cnt_t'(1);
   localparam ptr_t PTR_ONE   = ptr_t'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic        req_en_q;
   logic [31:0] fetch_ia_q,    fetch_ia_d;
   logic [31:0] rsp_ia_q,      rsp_ia_d;
   cnt_t        outstanding_q, outstanding_d;
   cnt_t        drop_q,        drop_d;
   cnt_t        count_q,       count_d;
   ptr_t        wr_ptr_q,      wr_ptr_d;
   ptr_t        rd_ptr_q,      rd_ptr_d;

   logic [31:0] ia_mem_q [QUEUE_DEPTH];
   logic [31:0] ir_mem_q [QUEUE_DEPTH];

   // ------------------------------------------------------------------
   // Event decode
   // ------------------------------------------------------------------
   logic [31:0] redirect_target;
   sum_t        inflight;
   logic        req_fire;
   logic        rsp_fire;
   logic        rsp_keep;
   logic        rsp_drop;
   logic        push;
   logic        pop;

   // The low address bits of a redirect are discarded by design.
   logic        unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_ia[1:0];

   assign redirect_target = {redirect_ia[31:2], 2'b00};

   // Credit: queued entries plus fetches still in the memory pipeline
   // (including ones that will be dropped) never exceed the queue depth,
   // so every kept response is guaranteed a free slot.
   assign inflight  = sum_t'(count_q) + sum_t'(outstanding_q);

   // req_en_q holds requests off while reset is asserted and for the first
   // cycle after release, so imem_req reads 0 throughout reset.
   assign imem_req  = req_en_q && !redirect_valid && (inflight < DEPTH_SUM);
   assign imem_addr = fetch_ia_q;

   assign req_fire  = imem_req && imem_gnt;
   // A response with nothing outstanding is a stale pre-reset beat; ignore it.
   assign rsp_fire  = imem_rvalid && (outstanding_q != '0);
   assign rsp_drop  = rsp_fire && (drop_q != '0);
   assign rsp_keep  = rsp_fire && (drop_q == '0);

   // A redirect wins over both queue operations in the same cycle.
   assign push      = rsp_keep && !redirect_valid;
   assign pop       = if_valid && if_ready && !redirect_valid;

   // ------------------------------------------------------------------
   // Next-state: fetch address, response address, credit counters
   // ------------------------------------------------------------------
   // Fetch-side bookkeeping: next fetch address, outstanding and drop counts.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      fetch_ia_d    = fetch_ia_q;
      rsp_ia_d      = rsp_ia_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;

      unique case ({req_fire, rsp_fire})
         2'b10:   outstanding_d = outstanding_q + CNT_ONE;
         2'b01:   outstanding_d = outstanding_q - CNT_ONE;
         default: outstanding_d = outstanding_q;
      endcase

      if (rsp_drop) begin
         drop_d = drop_q - CNT_ONE;
      end

      if (req_fire) begin
         fetch_ia_d = fetch_ia_q + 32'd4;
      end

      // The running response address tracks the next word to be kept; it
      // only advances on kept responses, since dropped ones precede them.
      if (push) begin
         rsp_ia_d = rsp_ia_q + 32'd4;
      end

      // Every fetch still in flight after this cycle belongs to the old
      // path and must be discarded when it returns.
      if (redirect_valid) begin
         fetch_ia_d = redirect_target;
         rsp_ia_d   = redirect_target;
         drop_d     = outstanding_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state: prefetch queue pointers and occupancy
   // ------------------------------------------------------------------
   // Circular-buffer pointer and occupancy update; redirect empties it.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (redirect_valid) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   // Control state: async reset, all updates on the rising clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_en_q      <= 1'b0;
         fetch_ia_q    <= INITIAL_IA;
         rsp_ia_q      <= INITIAL_IA;
         outstanding_q <= '0;
         drop_q        <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values regardless of block order.
         req_en_q      <= 1'b1;
         fetch_ia_q    <= fetch_ia_d;
         rsp_ia_q      <= rsp_ia_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // Queue storage: written on push, head read directly from the array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the storage is reset because the head fields are driven
         // straight from it and must read zero after reset; a deep queue
         // mapped to RAM would instead gate the outputs and skip this.
         for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
            ia_mem_q[i] <= '0;
            ir_mem_q[i] <= '0;
         end
      end else if (push) begin
         ia_mem_q[wr_ptr_q] <= rsp_ia_q;
         ir_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   // ------------------------------------------------------------------
   // IF/ID outputs
   // ------------------------------------------------------------------
   assign if_valid     = (count_q != '0);
   assign if_ia        = ia_mem_q[rd_ptr_q];
   assign if_ir        = ir_mem_q[rd_ptr_q];
   // Held at zero while the queue is empty so it reads 0 out of reset.
   assign if_ia_plus_4 = if_valid ? (if_ia + 32'd4) : 32'd0;

`ifdef MINA_FETCH_PERF_EN
   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_flushed_q;
   logic [31:0] perf_stall_q;
   logic [31:0] flush_inc;

   // Words lost to a redirect: queued entries, a kept word arriving in the
   // redirect cycle, and each old-path response dropped on return.
   always_comb begin
      flush_inc = 32'(rsp_drop);
      if (redirect_valid) begin
         flush_inc = flush_inc + 32'(count_q) + 32'(rsp_keep);
      end
   end

   // Free-running wrap-around event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
         perf_stall_q   <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_q + 32'(push);
         perf_flushed_q <= perf_flushed_q + flush_inc;
         perf_stall_q   <= perf_stall_q + 32'(if_ready && !if_valid);
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_mina_fetch_unit.sv
// tb_mina_fetch_unit: directed, scoreboard-checked bench for mina_fetch_unit.
// A bench-side memory model answers grants one cycle later; every word it
// returns on the current (not redirected) path is pushed to a scoreboard and
// compared when the DUT hands it across the IF/ID handshake. A second
// instance starts near the top of the address space to cover wrap-around.

module tb_mina_fetch_unit;

   logic        clk;
   logic        rst;

   // main instance
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_ia;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_ia;
   logic [31:0] if_ia_plus_4;
   logic [31:0] if_ir;

   // wrap-around instance
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic [31:0] w_if_ia;
   logic [31:0] w_if_ia_plus_4;
   logic [31:0] w_if_ir;

`ifdef MINA_FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushed, perf_stall;
   logic [31:0] w_perf_fetched, w_perf_flushed, w_perf_stall;
`endif

   mina_fetch_unit #(.INITIAL_IA(32'h0000_0000), .QUEUE_DEPTH(4)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_ia    (redirect_ia),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_ia          (if_ia),
      .if_ia_plus_4   (if_ia_plus_4),
      .if_ir          (if_ir)
`ifdef MINA_FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_flushed   (perf_flushed),
      .perf_stall     (perf_stall)
`endif
   );

   mina_fetch_unit #(.INITIAL_IA(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) u_wrap (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (w_req),
      .imem_addr      (w_addr),
      .imem_gnt       (1'b1),
      .imem_rvalid    (w_rvalid),
      .imem_rdata     (w_rdata),
      .redirect_valid (1'b0),
      .redirect_ia    (32'h0),
      .if_valid       (w_valid),
      .if_ready       (1'b1),
      .if_ia          (w_if_ia),
      .if_ia_plus_4   (w_if_ia_plus_4),
      .if_ir          (w_if_ir)
`ifdef MINA_FETCH_PERF_EN
      ,
      .perf_fetched   (w_perf_fetched),
      .perf_flushed   (w_perf_flushed),
      .perf_stall     (w_perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] ia;
      int          epoch;
   } req_t;

   typedef struct packed {
      logic [31:0] ia;
      logic [31:0] ir;
   } exp_t;

   req_t        pend[$];     // granted, not yet answered
   logic [31:0] pend2[$];    // same for the wrap instance
   exp_t        sb[$];       // words the DUT must deliver, in order
   logic [31:0] wrap_ia[$];
   logic [31:0] wrap_p4[$];

   int          n_cmp;
   int          n_err;
   int          n_grants;
   int          n_pops;
   int          epoch;
   logic [31:0] model_ia;
   logic        arrived_now;
   logic        rsp_hold;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd7) ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: observe mid-cycle, then answer the memory bus just
   // after the rising edge.
   task automatic tick();
      req_t        r;
      exp_t        e;
      logic [31:0] a;
      logic        exp_valid;
      @(negedge clk);
      if (!rst) begin
         exp_valid = (sb.size() - int'(arrived_now)) > 0;
         check("if_valid", {31'b0, if_valid}, {31'b0, exp_valid});
         if (imem_req && imem_gnt) begin
            check("imem_addr", imem_addr, model_ia);
            pend.push_back('{ia: model_ia, epoch: epoch});
            model_ia = model_ia + 32'd4;
            n_grants++;
         end
         if (if_valid && if_ready && !redirect_valid) begin
            n_pops++;
            if (sb.size() == 0) begin
               check("pop_unexpected", {31'b0, if_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("if_ia", if_ia, e.ia);
               check("if_ir", if_ir, e.ir);
               check("if_ia_plus_4", if_ia_plus_4, e.ia + 32'd4);
            end
         end
         if (redirect_valid) begin
            check("req_in_redirect", {31'b0, imem_req}, 32'd0);
            sb.delete();
            epoch++;
            model_ia = {redirect_ia[31:2], 2'b00};
         end
         if (w_req) pend2.push_back(w_addr);
         if (w_valid && wrap_ia.size() < 3) begin
            wrap_ia.push_back(w_if_ia);
            wrap_p4.push_back(w_if_ia_plus_4);
         end
      end
      @(posedge clk);
      #1;
      arrived_now = 1'b0;
      imem_rvalid = 1'b0;
      if (!rst && !rsp_hold && pend.size() > 0) begin
         r = pend.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(r.ia);
         if (r.epoch == epoch) begin
            sb.push_back('{ia: r.ia, ir: mem_word(r.ia)});
            arrived_now = 1'b1;
         end
      end
      w_rvalid = 1'b0;
      if (!rst && pend2.size() > 0) begin
         a = pend2.pop_front();
         w_rvalid = 1'b1;
         w_rdata  = mem_word(a);
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      imem_gnt       = 1'b1;
      imem_rvalid    = 1'b0;
      w_rvalid       = 1'b0;
      redirect_valid = 1'b0;
      redirect_ia    = 32'h0;
      if_ready       = 1'b1;
      rsp_hold       = 1'b0;
      arrived_now    = 1'b0;
      pend.delete();
      pend2.delete();
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      check("rst_imem_req", {31'b0, imem_req}, 32'd0);
      check("rst_if_valid", {31'b0, if_valid}, 32'd0);
      check("rst_if_ia", if_ia, 32'd0);
      check("rst_if_ir", if_ir, 32'd0);
      check("rst_if_ia_plus_4", if_ia_plus_4, 32'd0);
      rst      = 1'b0;
      model_ia = 32'h0;
   endtask

   initial begin
      int p0;
      int g0;
      int budget;
`ifdef MINA_FETCH_PERF_EN
      logic [31:0] fl0;
`endif
      n_cmp = 0; n_err = 0; n_grants = 0; n_pops = 0; epoch = 0;
      imem_rdata = 32'h0; w_rdata = 32'h0;

      // Reset, then free-running fetch with one-cycle memory.
      do_reset();
      repeat (6) tick();
      p0 = n_pops;
      repeat (8) tick();
      check("steady_one_per_cycle", n_pops - p0, 32'd8);

      // Wrap-around instance has delivered its first words by now.
      if (wrap_ia.size() < 3) begin
         check("wrap_count", wrap_ia.size(), 32'd3);
      end else begin
         check("wrap_ia0", wrap_ia[0], 32'hFFFF_FFF8);
         check("wrap_ia1", wrap_ia[1], 32'hFFFF_FFFC);
         check("wrap_ia2", wrap_ia[2], 32'h0000_0000);
         check("wrap_p4_at_fffffffc", wrap_p4[1], 32'h0000_0000);
      end

      // Back-pressure: queue fills, requests stop, release drains in order.
      if_ready = 1'b0;
      g0 = n_grants;
      repeat (10) tick();
      check("stall_grants_at_most_4", {31'b0, (n_grants - g0) <= 4}, 32'd1);
      check("stall_req_low", {31'b0, imem_req}, 32'd0);
      check("stall_if_valid", {31'b0, if_valid}, 32'd1);
      if_ready = 1'b1;
      p0 = n_pops;
      repeat (4) tick();
      check("release_pops", n_pops - p0, 32'd4);

      // Grant withheld: address must hold at 0x8 until granted.
      do_reset();
      g0 = n_grants;
      budget = 20;
      while ((n_grants - g0) < 2 && budget > 0) begin
         tick();
         budget--;
      end
      check("gnt_setup_timeout", {31'b0, budget > 0}, 32'd1);
      imem_gnt = 1'b0;
      repeat (3) begin
         tick();
         check("addr_hold", imem_addr, 32'h8);
         check("req_hold", {31'b0, imem_req}, 32'd1);
      end
      imem_gnt = 1'b1;
      g0 = n_grants;
      tick();
      check("resume_grant", n_grants - g0, 32'd1);
      repeat (6) tick();

      // Redirect with two fetches in flight: both late words discarded.
      do_reset();
      rsp_hold = 1'b1;
      budget = 20;
      while (pend.size() < 2 && budget > 0) begin
         tick();
         budget--;
      end
      check("outstanding_two", pend.size(), 32'd2);
      redirect_valid = 1'b1;
      redirect_ia    = 32'h0000_0103;
      tick();
      redirect_valid = 1'b0;
      check("redirect_addr", imem_addr, 32'h0000_0100);
      rsp_hold = 1'b0;
      budget = 20;
      while (!if_valid && budget > 0) begin
         tick();
         budget--;
      end
      check("first_after_redirect", if_ia, 32'h0000_0100);
      repeat (6) tick();

      // Kept rvalid, pop and redirect together with two entries queued.
      do_reset();
      if_ready = 1'b0;
      g0 = n_grants;
      budget = 20;
      do begin
         tick();
         if ((n_grants - g0) >= 3) imem_gnt = 1'b0;
         budget--;
      end while (sb.size() < 3 && budget > 0);
      check("same_cycle_setup", {31'b0, arrived_now}, 32'd1);
`ifdef MINA_FETCH_PERF_EN
      fl0 = perf_flushed;
`endif
      if_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_ia    = 32'h0000_0200;
      tick();
      redirect_valid = 1'b0;
      check("flush_if_valid", {31'b0, if_valid}, 32'd0);
`ifdef MINA_FETCH_PERF_EN
      check("perf_flushed_delta", perf_flushed - fl0, 32'd3);
`endif
      imem_gnt = 1'b1;
      budget = 20;
      while (!if_valid && budget > 0) begin
         tick();
         budget--;
      end
      check("first_after_flush", if_ia, 32'h0000_0200);
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mina_fetch_unit.md
Name: mina_fetch_unit

Overview:
Parametrised successor of the single-register IA/IF logic in the MINA CPU top level. It owns the instruction address and issues pipelined requests on a split request/response IMEM bus. Returned words are buffered in a QUEUE_DEPTH-entry prefetch queue. The block feeds the IF/ID boundary through a valid/ready handshake and supports branch redirect with flush of queued and in-flight fetches.

Parameters:
INITIAL_IA, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
QUEUE_DEPTH, 4, prefetch queue entries; power of two, 2..16. Also the cap on queued plus outstanding fetches.
MAX_DROP_W, $clog2(QUEUE_DEPTH)+1, width of the outstanding and drop counters.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address; word aligned.
imem_gnt  input  1  request accepted this cycle when imem_req=1.
imem_rvalid  input  1  response valid; responses return in order, at least 1 cycle after grant.
imem_rdata  input  32  instruction word.
redirect_valid  input  1  branch/jump taken; flush and refetch.
redirect_ia  input  32  new fetch address; bits [1:0] ignored and forced to 0.
if_valid  output  1  queue head valid toward ID.
if_ready  input  1  ID accepts the head.
if_ia  output  32  address of the head instruction.
if_ia_plus_4  output  32  if_ia + 4, modulo 2^32.
if_ir  output  32  head instruction word.

Behaviour:
- Reset (async assert, sync release): fetch_ia=INITIAL_IA; queue empty; outstanding=0; drop=0; imem_req=0; if_valid=0; if_ia/if_ir/if_ia_plus_4=0.
- imem_req=1 when (queue_count + outstanding) < QUEUE_DEPTH and redirect_valid=0. imem_addr=fetch_ia.
- imem_req is combinational from registered state and redirect_valid. imem_addr may not change while imem_req=1 and imem_gnt=0, unless a redirect occurs.
- On grant: fetch_ia <= fetch_ia + 4 (wraps 32'hFFFF_FFFC -> 0); outstanding++.
- On rvalid with drop=0: push {addr, rdata} into the queue; outstanding--. The address comes from a tag FIFO or a running response address.
- On rvalid with drop>0: discard the word; drop--; outstanding--.
- Grant and rvalid in the same cycle: outstanding is unchanged.
- Queue: registered circular buffer. if_valid = !empty. Head fields are driven directly from storage. Pop on if_valid && if_ready.
- Push and pop in the same cycle are allowed at any occupancy. Overflow is impossible by the credit rule.
- Zero-bubble case: a response arriving into an empty queue is visible on if_valid the next cycle. Minimum latency is grant -> rvalid -> if_valid, i.e. 1 cycle after rvalid.
- Redirect (highest priority, same cycle):
  - Queue cleared; a pop in the same cycle is ignored.
  - fetch_ia <= {redirect_ia[31:2],2'b00}.
  - drop <= outstanding_next, counting any grant this cycle and excluding an rvalid this cycle.
  - outstanding is unchanged.
  - imem_req=0 during the redirect cycle. Requests resume the next cycle.
- Back-to-back redirects: the last one wins; drop keeps accumulating correctly.
- A new fetch may issue while drop>0. Its responses are kept because in-order return guarantees dropped responses arrive first.
- Reset mid-operation: all state is cleared immediately. In-flight responses after reset release are ignored until a request is granted. The bench must not return stale responses after reset.

Optional Feature:
MINA_FETCH_PERF_EN
- Defined: adds outputs perf_fetched[31:0] (kept responses), perf_flushed[31:0] (queue entries plus dropped responses discarded by redirects) and perf_stall[31:0] (cycles with if_ready=1 and if_valid=0). Counters wrap and reset to 0.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset release; imem always grants, rvalid 1 cycle after grant; if_ready=1 -> if_ia sequence 0x0,0x4,0x8..., with if_ir matching memory. Steady state gives one instruction per cycle.
- if_ready=0 for 10 cycles, QUEUE_DEPTH=4 -> at most 4 grants; imem_req=0 once the queue is full; release gives 4 pops in order.
- imem_gnt held 0 for 3 cycles -> imem_addr stable at 0x8 throughout; fetch resumes at 0x8.
- Redirect to 0x103 with 2 responses outstanding -> next request addr 0x100; the 2 late rvalids are discarded; first if_ia after that is 0x100.
- INITIAL_IA=32'hFFFF_FFF8 -> if_ia sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; if_ia_plus_4 at 0xFFFF_FFFC equals 0x0.
- Rvalid, pop and redirect in the same cycle with queue count 2 -> queue empty next cycle, if_valid=0. With MINA_FETCH_PERF_EN defined, perf_flushed increments by 3 (2 entries plus the rvalid).
